sfence_vma_seq: RTL and testbench

// - Sequences one SFENCE.VMA from issue to TLB flush, between the EX-stage issue port and the LSU MMU flush inputs.
// - Captures rs1 (vaddr) and rs2 (asid) operands at issue.
// - Holds them until the instruction commits and all outstanding stores have drained.
// - Then emits a one-cycle TLB flush request with qualified vaddr/asid scope.

---
 rtl/sfence_vma_seq_if.sv | 25 ++
 rtl/sfence_vma_seq.sv | 126 ++++++++++++
 tb/tb_sfence_vma_seq.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sfence_vma_seq_if.sv
// Issue-side handshake between the EX stage and the SFENCE.VMA sequencer.
// An op transfers on a clock edge where issue_valid && issue_ready; issue_ready depends only on sequencer state.
interface sfence_vma_seq_if #(
  parameter int unsigned VLEN          = 39,
  parameter int unsigned ASID_WIDTH    = 1,
  parameter int unsigned TRANS_ID_BITS = 3
);
  logic                     issue_valid;
  logic                     issue_ready;
  logic [VLEN-1:0]          rs1;
  logic [ASID_WIDTH-1:0]    rs2;
  logic                     rs1_is_x0;
  logic                     rs2_is_x0;
  logic [TRANS_ID_BITS-1:0] trans_id;

  modport master (
    output issue_valid, rs1, rs2, rs1_is_x0, rs2_is_x0, trans_id,
    input  issue_ready
  );

  modport slave (
    input  issue_valid, rs1, rs2, rs1_is_x0, rs2_is_x0, trans_id,
    output issue_ready
  );
endinterface

// File: rtl/sfence_vma_seq.sv
// Sequences one SFENCE.VMA from issue, through commit and store drain, to a one-cycle TLB flush pulse.
module sfence_vma_seq #(
  parameter int unsigned ASID_WIDTH    = 1,
  parameter int unsigned VLEN          = 39,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned CNT_W         = 10
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clr_i,
  input  logic                     flush_i,
  sfence_vma_seq_if.slave          issue,
  input  logic                     commit_i,
  input  logic [TRANS_ID_BITS-1:0] commit_trans_id_i,
  input  logic                     no_st_pending_i,
  input  logic                     wbuffer_empty_i,
  output logic                     flush_tlb_o,
  output logic [VLEN-1:0]          flush_vaddr_o,
  output logic [ASID_WIDTH-1:0]    flush_asid_o,
  output logic                     flush_all_vaddr_o,
  output logic                     flush_all_asid_o,
  output logic                     busy_o,
  output logic [CNT_W-1:0]         drain_cycles_o,
  output logic [1:0]               state_o
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_COMMIT = 2'd1,
    DRAIN       = 2'd2,
    FLUSH       = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e                   state_q, state_d;
  logic [VLEN-1:0]          vaddr_q;
  logic [ASID_WIDTH-1:0]    asid_q;
  logic                     all_vaddr_q;
  logic                     all_asid_q;
  logic [TRANS_ID_BITS-1:0] id_q;
  logic [CNT_W-1:0]         cnt_q;

  logic accept;
  logic commit_match;
  logic drained;
  logic cnt_inc;

  assign accept       = (state_q == IDLE) && issue.issue_valid;
  assign commit_match = commit_i && (commit_trans_id_i == id_q);
  assign drained      = no_st_pending_i && wbuffer_empty_i;
  assign cnt_inc      = (state_q == DRAIN) && !drained && (cnt_q != CNT_MAX);

  // A matching commit beats a same-cycle squash: the op is architecturally done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (issue.issue_valid) state_d = WAIT_COMMIT;
      end
      WAIT_COMMIT: begin
        if (commit_match)  state_d = DRAIN;
        else if (flush_i)  state_d = IDLE;
      end
      DRAIN: begin
        if (drained) state_d = FLUSH;
      end
      FLUSH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else if (clr_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Captured operands stay put after the pulse so the scope remains visible until the next accept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vaddr_q     <= '0;
      asid_q      <= '0;
      all_vaddr_q <= 1'b0;
      all_asid_q  <= 1'b0;
      id_q        <= '0;
      cnt_q       <= '0;
    end else if (clr_i) begin
      vaddr_q     <= '0;
      asid_q      <= '0;
      all_vaddr_q <= 1'b0;
      all_asid_q  <= 1'b0;
      id_q        <= '0;
      cnt_q       <= '0;
    end else if (accept) begin
      vaddr_q     <= issue.rs1;
      asid_q      <= issue.rs2;
      all_vaddr_q <= issue.rs1_is_x0;
      all_asid_q  <= issue.rs2_is_x0;
      id_q        <= issue.trans_id;
      cnt_q       <= '0;
    end else if (cnt_inc) begin
      cnt_q       <= cnt_q + CNT_ONE;
    end
  end

  assign issue.issue_ready = (state_q == IDLE);
  assign flush_tlb_o       = (state_q == FLUSH);
  assign busy_o            = (state_q != IDLE);
  assign flush_vaddr_o     = vaddr_q;
  assign flush_asid_o      = asid_q;
  assign flush_all_vaddr_o = all_vaddr_q;
  assign flush_all_asid_o  = all_asid_q;
  assign drain_cycles_o    = cnt_q;
  assign state_o           = state_q;

endmodule

// File: tb/tb_sfence_vma_seq.sv
// Self-checking bench for sfence_vma_seq: directed scenarios plus randomized ops against a timeline model.
module tb_sfence_vma_seq;
  localparam int VLEN   = 39;
  localparam int ASID_W = 1;
  localparam int TID    = 3;

  typedef struct packed {
    logic [VLEN-1:0]   vaddr;
    logic [ASID_W-1:0] asid;
    logic              all_v;
    logic              all_a;
    logic [TID-1:0]    id;
  } op_t;

  typedef struct packed {
    logic              ready, tlb, busy, all_v, all_a;
    logic [ASID_W-1:0] asid;
    logic [VLEN-1:0]   vaddr;
    logic [9:0]        drain;
    logic              ready_s, tlb_s, busy_s, all_v_s, all_a_s;
    logic [ASID_W-1:0] asid_s;
    logic [VLEN-1:0]   vaddr_s;
    logic [2:0]        drain_s;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_ni, clr, flush, commit, no_st, wbuf;
  logic [TID-1:0] commit_id;

  logic tlb, all_v, all_a, busy;
  logic [VLEN-1:0] vaddr;
  logic [ASID_W-1:0] asid;
  logic [9:0] drain;
  logic [1:0] st;
  logic tlb_s, all_v_s, all_a_s, busy_s;
  logic [VLEN-1:0] vaddr_s;
  logic [ASID_W-1:0] asid_s;
  logic [2:0] drain_s;
  logic [1:0] st_s;

  sfence_vma_seq_if #(.VLEN(VLEN), .ASID_WIDTH(ASID_W), .TRANS_ID_BITS(TID)) bus ();
  sfence_vma_seq_if #(.VLEN(VLEN), .ASID_WIDTH(ASID_W), .TRANS_ID_BITS(TID)) bus_s ();

  assign bus_s.issue_valid = bus.issue_valid;
  assign bus_s.rs1         = bus.rs1;
  assign bus_s.rs2         = bus.rs2;
  assign bus_s.rs1_is_x0   = bus.rs1_is_x0;
  assign bus_s.rs2_is_x0   = bus.rs2_is_x0;
  assign bus_s.trans_id    = bus.trans_id;

  sfence_vma_seq #(.ASID_WIDTH(ASID_W), .VLEN(VLEN), .TRANS_ID_BITS(TID), .CNT_W(10)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .clr_i(clr), .flush_i(flush), .issue(bus.slave),
    .commit_i(commit), .commit_trans_id_i(commit_id), .no_st_pending_i(no_st), .wbuffer_empty_i(wbuf),
    .flush_tlb_o(tlb), .flush_vaddr_o(vaddr), .flush_asid_o(asid), .flush_all_vaddr_o(all_v),
    .flush_all_asid_o(all_a), .busy_o(busy), .drain_cycles_o(drain), .state_o(st)
  );

  sfence_vma_seq #(.ASID_WIDTH(ASID_W), .VLEN(VLEN), .TRANS_ID_BITS(TID), .CNT_W(3)) dut_s (
    .clk_i(clk), .rst_ni(rst_ni), .clr_i(clr), .flush_i(flush), .issue(bus_s.slave),
    .commit_i(commit), .commit_trans_id_i(commit_id), .no_st_pending_i(no_st), .wbuffer_empty_i(wbuf),
    .flush_tlb_o(tlb_s), .flush_vaddr_o(vaddr_s), .flush_asid_o(asid_s), .flush_all_vaddr_o(all_v_s),
    .flush_all_asid_o(all_a_s), .busy_o(busy_s), .drain_cycles_o(drain_s), .state_o(st_s)
  );

  int checks = 0;
  int errors = 0;
  op_t zero_op = '0;

  // Expected visible outputs from the sequencer's rules: busy phase, pulse, last accepted op, drain count so far.
  function automatic obs_t model(input logic bsy, input logic pulse, input op_t op, input int d);
    obs_t m;
    m.ready   = !bsy;       m.ready_s = !bsy;
    m.tlb     = pulse;      m.tlb_s   = pulse;
    m.busy    = bsy;        m.busy_s  = bsy;
    m.all_v   = op.all_v;   m.all_v_s = op.all_v;
    m.all_a   = op.all_a;   m.all_a_s = op.all_a;
    m.asid    = op.asid;    m.asid_s  = op.asid;
    m.vaddr   = op.vaddr;   m.vaddr_s = op.vaddr;
    m.drain   = (d > 1023) ? 10'd1023 : 10'(d);
    m.drain_s = (d > 7) ? 3'd7 : 3'(d);
    return m;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.ready = bus.issue_ready;   o.ready_s = bus_s.issue_ready;
    o.tlb   = tlb;   o.tlb_s   = tlb_s;
    o.busy  = busy;  o.busy_s  = busy_s;
    o.all_v = all_v; o.all_v_s = all_v_s;
    o.all_a = all_a; o.all_a_s = all_a_s;
    o.asid  = asid;  o.asid_s  = asid_s;
    o.vaddr = vaddr; o.vaddr_s = vaddr_s;
    o.drain = drain; o.drain_s = drain_s;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t op;
    op.vaddr = VLEN'({$urandom(), $urandom()});
    op.asid  = ASID_W'($urandom_range(0, 1));
    op.all_v = 1'($urandom_range(0, 1));
    op.all_a = 1'($urandom_range(0, 1));
    op.id    = TID'($urandom_range(0, 7));
    return op;
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic quiet();
    bus.issue_valid = 1'b0;
    commit = 1'b0; flush = 1'b0; clr = 1'b0;
    no_st = 1'b1; wbuf = 1'b1;
  endtask

  task automatic drive_issue(input op_t op);
    bus.issue_valid = 1'b1;
    bus.rs1 = op.vaddr; bus.rs2 = op.asid;
    bus.rs1_is_x0 = op.all_v; bus.rs2_is_x0 = op.all_a; bus.trans_id = op.id;
  endtask

  task automatic do_clr();
    quiet(); clr = 1'b1; cyc(); clr = 1'b0;
  endtask

  task automatic test_reset();
    obs_t got, exp;
    quiet(); rst_ni = 1'b0;
    drive_issue(rand_op());
    repeat (2) cyc();
    checks++; got = sample(); exp = model(1'b0, 1'b0, zero_op, 0);
    if (got !== exp) begin errors++; $display("FAIL reset_hold got=%h exp=%h", got, exp); end
    bus.issue_valid = 1'b0; rst_ni = 1'b1; cyc();
    checks++; got = sample();
    if (got !== exp) begin errors++; $display("FAIL reset_release got=%h exp=%h", got, exp); end
  endtask

  task automatic test_basic();
    obs_t got, exp;
    op_t op;
    op = '{vaddr: VLEN'(39'h1000), asid: 1'b1, all_v: 1'b0, all_a: 1'b0, id: 3'd2};
    do_clr(); drive_issue(op); cyc(); quiet();
    checks++; got = sample(); exp = model(1'b1, 1'b0, op, 0);
    if (got !== exp) begin errors++; $display("FAIL t1_wait got=%h exp=%h", got, exp); end
    commit = 1'b1; commit_id = 3'd2; cyc(); quiet();
    checks++; got = sample(); exp = model(1'b1, 1'b0, op, 0);
    if (got !== exp) begin errors++; $display("FAIL t1_drain got=%h exp=%h", got, exp); end
    cyc();
    checks++; got = sample(); exp = model(1'b1, 1'b1, op, 0);
    if (got !== exp) begin errors++; $display("FAIL t1_pulse_cycle3 got=%h exp=%h", got, exp); end
    cyc();
    checks++; got = sample(); exp = model(1'b0, 1'b0, op, 0);
    if (got !== exp) begin errors++; $display("FAIL t1_after got=%h exp=%h", got, exp); end
  endtask

  task automatic test_x0();
    obs_t got, exp;
    op_t op;
    op = rand_op(); op.all_v = 1'b1; op.all_a = 1'b1;
    do_clr(); drive_issue(op); cyc(); quiet();
    commit = 1'b1; commit_id = op.id; cyc(); quiet();
    cyc();
    checks++; got = sample(); exp = model(1'b1, 1'b1, op, 0);
    if (got !== exp) begin errors++; $display("FAIL t2_x0_pulse got=%h exp=%h", got, exp); end
  endtask

  task automatic test_flush_wait();
    obs_t got, exp;
    op_t op;
    op = rand_op(); op.id = 3'd4;
    do_clr(); drive_issue(op); cyc(); quiet();
    flush = 1'b1; cyc(); quiet();
    checks++; got = sample(); exp = model(1'b0, 1'b0, op, 0);
    if (got !== exp) begin errors++; $display("FAIL t3_squash got=%h exp=%h", got, exp); end
    commit = 1'b1; commit_id = 3'd4; cyc(); quiet(); cyc();
    checks++; got = sample();
    if (got !== exp) begin errors++; $display("FAIL t3_no_pulse got=%h exp=%h", got, exp); end
  endtask

  task automatic test_commit_flush();
    obs_t got, exp;
    op_t op;
    op = rand_op(); op.id = 3'd4;
    do_clr(); drive_issue(op); cyc(); quiet();
    commit = 1'b1; commit_id = 3'd5; cyc(); quiet();
    checks++; got = sample(); exp = model(1'b1, 1'b0, op, 0);
    if (got !== exp) begin errors++; $display("FAIL t4_wrong_id got=%h exp=%h", got, exp); end
    commit = 1'b1; commit_id = 3'd4; flush = 1'b1; cyc(); quiet();
    flush = 1'b1; no_st = 1'b0; cyc(); quiet();
    checks++; got = sample(); exp = model(1'b1, 1'b0, op, 1);
    if (got !== exp) begin errors++; $display("FAIL t4_drain_ignores_flush got=%h exp=%h", got, exp); end
    cyc();
    checks++; got = sample(); exp = model(1'b1, 1'b1, op, 1);
    if (got !== exp) begin errors++; $display("FAIL t4_pulse got=%h exp=%h", got, exp); end
  endtask

  task automatic test_same_cycle_commit();
    obs_t got, exp;
    op_t op;
    op = rand_op();
    do_clr(); drive_issue(op); commit = 1'b1; commit_id = op.id; cyc(); quiet();
    cyc();
    checks++; got = sample(); exp = model(1'b1, 1'b0, op, 0);
    if (got !== exp) begin errors++; $display("FAIL issue_cycle_commit got=%h exp=%h", got, exp); end
    commit = 1'b1; commit_id = op.id; cyc(); quiet(); cyc();
    checks++; got = sample(); exp = model(1'b1, 1'b1, op, 0);
    if (got !== exp) begin errors++; $display("FAIL issue_cycle_commit_pulse got=%h exp=%h", got, exp); end
  endtask

  task automatic test_drain();
    obs_t got, exp;
    op_t op;
    op = rand_op();
    do_clr(); drive_issue(op); cyc(); quiet();
    commit = 1'b1; commit_id = op.id; cyc(); quiet();
    for (int k = 0; k < 7; k++) begin
      checks++; got = sample(); exp = model(1'b1, 1'b0, op, k);
      if (got !== exp) begin errors++; $display("FAIL t5_drain_%0d got=%h exp=%h", k, got, exp); end
      no_st = 1'b0; cyc(); quiet();
    end
    cyc();
    checks++; got = sample(); exp = model(1'b1, 1'b1, op, 7);
    if (got !== exp) begin errors++; $display("FAIL t5_pulse_7 got=%h exp=%h", got, exp); end
    cyc();
    op = rand_op(); drive_issue(op); cyc(); quiet();
    commit = 1'b1; commit_id = op.id; cyc(); quiet();
    for (int k = 0; k < 20; k++) begin
      wbuf = 1'b0; no_st = k[0]; cyc(); quiet();
    end
    checks++; got = sample(); exp = model(1'b1, 1'b0, op, 20);
    if (got !== exp) begin errors++; $display("FAIL t5_saturate got=%h exp=%h", got, exp); end
    cyc(); cyc();
    checks++; got = sample(); exp = model(1'b0, 1'b0, op, 20);
    if (got !== exp) begin errors++; $display("FAIL t5_hold_after got=%h exp=%h", got, exp); end
  endtask

  task automatic test_reset_mid();
    obs_t got, exp;
    op_t op;
    op = rand_op();
    do_clr(); drive_issue(op); cyc(); quiet();
    commit = 1'b1; commit_id = op.id; cyc(); quiet();
    no_st = 1'b0; cyc(); no_st = 1'b0; cyc();
    #2 rst_ni = 1'b0;
    #1;
    checks++; got = sample(); exp = model(1'b0, 1'b0, zero_op, 0);
    if (got !== exp) begin errors++; $display("FAIL t6_async_rst got=%h exp=%h", got, exp); end
    cyc(); rst_ni = 1'b1; quiet(); cyc();
    checks++; got = sample();
    if (got !== exp) begin errors++; $display("FAIL t6_rst_no_pulse got=%h exp=%h", got, exp); end
    op = rand_op(); drive_issue(op); cyc(); quiet();
    commit = 1'b1; commit_id = op.id; cyc(); quiet();
    no_st = 1'b0; cyc();
    clr = 1'b1; no_st = 1'b0; drive_issue(rand_op()); cyc(); quiet();
    checks++; got = sample(); exp = model(1'b0, 1'b0, zero_op, 0);
    if (got !== exp) begin errors++; $display("FAIL t6_sync_clr got=%h exp=%h", got, exp); end
    cyc();
    checks++; got = sample();
    if (got !== exp) begin errors++; $display("FAIL t6_clr_no_pulse got=%h exp=%h", got, exp); end
  endtask

  // Random ops issued back to back; the expected timeline follows commit delay, squash and drain length.
  task automatic test_random();
    obs_t got, exp;
    op_t op, prev, junk;
    int prev_d, w, d;
    logic [TID-1:0] wid;
    do_clr(); prev = zero_op; prev_d = 0;
    for (int n = 0; n < 60; n++) begin
      op = rand_op();
      w = $urandom_range(0, 3);
      d = $urandom_range(0, 10);
      checks++; got = sample(); exp = model(1'b0, 1'b0, prev, prev_d);
      if (got !== exp) begin errors++; $display("FAIL rnd_idle op=%0d got=%h exp=%h", n, got, exp); end
      quiet(); drive_issue(op);
      if ($urandom_range(0, 3) == 0) begin commit = 1'b1; commit_id = op.id; end
      cyc(); quiet();
      for (int i = 0; i < w; i++) begin
        checks++; got = sample(); exp = model(1'b1, 1'b0, op, 0);
        if (got !== exp) begin errors++; $display("FAIL rnd_wait op=%0d got=%h exp=%h", n, got, exp); end
        wid = op.id + TID'($urandom_range(1, 7));
        commit = 1'($urandom_range(0, 1)); commit_id = wid;
        junk = rand_op(); drive_issue(junk);
        cyc(); quiet();
      end
      checks++; got = sample(); exp = model(1'b1, 1'b0, op, 0);
      if (got !== exp) begin errors++; $display("FAIL rnd_pre_commit op=%0d got=%h exp=%h", n, got, exp); end
      if ($urandom_range(0, 5) == 0) begin
        flush = 1'b1; cyc(); quiet();
        prev = op; prev_d = 0;
        continue;
      end
      commit = 1'b1; commit_id = op.id; flush = 1'($urandom_range(0, 1));
      cyc(); quiet();
      for (int k = 0; k < d; k++) begin
        checks++; got = sample(); exp = model(1'b1, 1'b0, op, k);
        if (got !== exp) begin errors++; $display("FAIL rnd_drain op=%0d k=%0d got=%h exp=%h", n, k, got, exp); end
        case ($urandom_range(0, 2))
          0: no_st = 1'b0;
          1: wbuf = 1'b0;
          default: begin no_st = 1'b0; wbuf = 1'b0; end
        endcase
        flush = 1'($urandom_range(0, 1));
        cyc(); quiet();
      end
      checks++; got = sample(); exp = model(1'b1, 1'b0, op, d);
      if (got !== exp) begin errors++; $display("FAIL rnd_last_drain op=%0d got=%h exp=%h", n, got, exp); end
      cyc();
      checks++; got = sample(); exp = model(1'b1, 1'b1, op, d);
      if (got !== exp) begin errors++; $display("FAIL rnd_pulse op=%0d got=%h exp=%h", n, got, exp); end
      cyc();
      prev = op; prev_d = d;
    end
  endtask

  initial begin
    rst_ni = 1'b0; commit_id = '0;
    bus.rs1 = '0; bus.rs2 = '0; bus.rs1_is_x0 = 1'b0; bus.rs2_is_x0 = 1'b0; bus.trans_id = '0;
    quiet();
    cyc();
    test_reset();
    test_basic();
    test_x0();
    test_flush_wait();
    test_commit_flush();
    test_same_cycle_commit();
    test_drain();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
